// File: rtl/output_stage.sv
// ============================================================================
// output_stage : selects one of four input phits for this output port, strips
// the route field from newly granted heads, tracks framing, counts packets.
// Revision: 1.0
// ============================================================================
`default_nettype none

module output_stage #(
  parameter int PHIT_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [PHIT_W-1:0] in0,
  input  logic [PHIT_W-1:0] in1,
  input  logic [PHIT_W-1:0] in2,
  input  logic [PHIT_W-1:0] in3,
  input  logic [3:0]        select,
  input  logic              shift,
  output logic [PHIT_W-1:0] out_phit,
  output logic              out_sop,
  output logic [CNT_W-1:0]  pkt_count,
  output logic [CNT_W-1:0]  phit_count,
  output logic              err_multi,
  output logic              err_proto
);

  localparam logic [1:0]       C_TYPE_HEAD    = 2'b11;
  localparam logic [1:0]       C_TYPE_PAYLOAD = 2'b10;
  localparam logic [CNT_W-1:0] C_CNT_ONE      = CNT_W'(1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [3:0]        r_last_sel;
  logic [3:0]        w_last_sel_nxt;
  logic [PHIT_W-1:0] w_sel_phit;
  logic [PHIT_W-1:0] w_head_phit;
  logic [PHIT_W-1:0] w_phit_nxt;
  logic [1:0]        w_type;
  logic              w_onehot;
  logic              w_multi;
  logic              w_sop_nxt;
  logic              w_pkt_inc;
  logic              w_set_multi;
  logic              w_set_proto;

  always_comb begin
    w_sel_phit = '0;
    case (select)
      4'b0001: w_sel_phit = in0;
      4'b0010: w_sel_phit = in1;
      4'b0100: w_sel_phit = in2;
      4'b1000: w_sel_phit = in3;
      default: w_sel_phit = '0;
    endcase
  end

  assign w_onehot    = (select != 4'd0) && ((select & (select - 4'd1)) == 4'd0);
  assign w_multi     = (select != 4'd0) && !w_onehot;
  assign w_type      = w_sel_phit[PHIT_W-1 -: 2];
  // Consumed route field drops out; the next hop's route moves to the top.
  assign w_head_phit = {C_TYPE_HEAD, w_sel_phit[PHIT_W-5:0], 2'b00};

  always_comb begin
    w_state_nxt    = r_state;
    w_last_sel_nxt = r_last_sel;
    w_phit_nxt     = '0;
    w_sop_nxt      = 1'b0;
    w_pkt_inc      = 1'b0;
    w_set_multi    = 1'b0;
    w_set_proto    = 1'b0;
    if (w_multi) begin
      w_set_multi = 1'b1;
      w_state_nxt = IDLE;
    end else if (select == 4'd0) begin
      w_set_proto = shift;
      w_state_nxt = IDLE;
    end else if (shift && (w_type == C_TYPE_HEAD)) begin
      // New packet; a back-to-back head from any port is accepted in BUSY too.
      w_phit_nxt     = w_head_phit;
      w_sop_nxt      = 1'b1;
      w_pkt_inc      = 1'b1;
      w_last_sel_nxt = select;
      w_state_nxt    = BUSY;
    end else if ((r_state == BUSY) && !shift && (w_type == C_TYPE_PAYLOAD) &&
                 (select == r_last_sel)) begin
      w_phit_nxt = w_sel_phit;
    end else begin
      w_set_proto = 1'b1;
      w_state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_last_sel <= 4'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_last_sel <= w_last_sel_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_phit   <= '0;
      out_sop    <= 1'b0;
      pkt_count  <= '0;
      phit_count <= '0;
      err_multi  <= 1'b0;
      err_proto  <= 1'b0;
    end else begin
      out_phit  <= w_phit_nxt;
      out_sop   <= w_sop_nxt;
      err_multi <= err_multi | w_set_multi;
      err_proto <= err_proto | w_set_proto;
      if (w_pkt_inc) begin
        pkt_count <= pkt_count + C_CNT_ONE;
      end
      if (w_phit_nxt != '0) begin
        phit_count <= phit_count + C_CNT_ONE;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_output_stage.sv
// ============================================================================
// tb_output_stage : directed and randomized checks of output_stage against a
// packet-level reference model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_output_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] in0 = '0, in1 = '0, in2 = '0, in3 = '0;
  logic [3:0]  select = '0;
  logic        shift = 1'b0;
  logic [15:0] out_phit, pkt_count, phit_count;
  logic        out_sop, err_multi, err_proto;

  int n_chk = 0;
  int n_err = 0;

  // reference model state
  bit          m_busy;
  int          m_port;
  logic [15:0] m_phit, m_pkt, m_phc;
  bit          m_sop, m_em, m_ep;

  output_stage #(.PHIT_W(16), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in0(in0), .in1(in1), .in2(in2), .in3(in3),
    .select(select), .shift(shift),
    .out_phit(out_phit), .out_sop(out_sop),
    .pkt_count(pkt_count), .phit_count(phit_count),
    .err_multi(err_multi), .err_proto(err_proto)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_port = -1; m_phit = '0; m_pkt = '0; m_phc = '0;
    m_sop = 0; m_em = 0; m_ep = 0;
  endtask

  // Packet-level rules: a head granted with shift opens a packet on that port,
  // payload must follow on the same port without shift, anything else is a fault.
  task automatic model_step(input logic [3:0] s, input logic sh,
                            input logic [15:0] a, b, c, d);
    logic [15:0] ins [4];
    logic [15:0] ph;
    int cnt, p, t;
    ins[0] = a; ins[1] = b; ins[2] = c; ins[3] = d;
    cnt = $countones(s);
    m_phit = '0; m_sop = 0;
    if (cnt > 1) begin
      m_em = 1; m_busy = 0;
    end else if (cnt == 0) begin
      if (sh) m_ep = 1;
      m_busy = 0;
    end else begin
      p = 0;
      for (int i = 0; i < 4; i++) if (s[i]) p = i;
      ph = ins[p];
      t = int'(ph) / 16384;
      if (sh && t == 3) begin
        m_phit = 16'((int'(ph) % 4096) * 4 + 16'hC000);
        m_sop = 1; m_pkt = m_pkt + 16'd1; m_busy = 1; m_port = p;
      end else if (m_busy && !sh && t == 2 && p == m_port) begin
        m_phit = ph;
      end else begin
        m_ep = 1; m_busy = 0;
      end
    end
    if (m_phit != 0) m_phc = m_phc + 16'd1;
  endtask

  task automatic check_all();
    chk("phit", out_phit, m_phit);
    chk("sop", out_sop, m_sop);
    chk("pkt", pkt_count, m_pkt);
    chk("phc", phit_count, m_phc);
    chk("emul", err_multi, m_em);
    chk("eprt", err_proto, m_ep);
  endtask

  task automatic cyc(input logic [3:0] s, input logic sh,
                     input logic [15:0] a, b, c, d);
    @(negedge clk);
    select = s; shift = sh; in0 = a; in1 = b; in2 = c; in3 = d;
    @(posedge clk);
    model_step(s, sh, a, b, c, d);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    select = '0; shift = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic rnd_cycle();
    int r;
    logic [3:0] s;
    logic sh;
    logic [15:0] v [4];
    int p;
    for (int i = 0; i < 4; i++) v[i] = 16'($urandom);
    r = $urandom_range(0, 99);
    p = $urandom_range(0, 3);
    s = 4'd1 << p; sh = 1'b0;
    if (m_busy && r < 60) begin
      s = 4'd1 << m_port;
      v[m_port] = {2'b10, 14'($urandom)};
    end else if (r < 82) begin
      sh = 1'b1;
      v[p] = {2'b11, 14'($urandom)};
    end else if (r < 92) begin
      s = 4'd0;
    end else if (r < 95) begin
      s = 4'd0; sh = 1'b1;
    end else if (r < 97) begin
      s = 4'b0110;
    end else begin
      sh = 1'($urandom);
    end
    cyc(s, sh, v[0], v[1], v[2], v[3]);
  endtask

  initial begin
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    // basic packet through port 2
    cyc(4'b0100, 1'b1, 16'h0, 16'h0, 16'hE5A3, 16'h0);
    chk("head_d68c", out_phit, 16'hD68C);
    chk("head_sop", out_sop, 1'b1);
    cyc(4'b0100, 1'b0, 16'h0, 16'h0, 16'h9111, 16'h0);
    cyc(4'b0100, 1'b0, 16'h0, 16'h0, 16'h9111, 16'h0);
    chk("pay_9111", out_phit, 16'h9111);
    cyc(4'b0000, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0);
    chk("pkt_one", pkt_count, 16'd1);
    chk("phc_three", phit_count, 16'd3);

    // back-to-back head on a different port
    cyc(4'b0010, 1'b1, 16'h0, 16'hC123, 16'h0, 16'h0);
    cyc(4'b0010, 1'b0, 16'h0, 16'h8ABC, 16'h0, 16'h0);
    cyc(4'b1000, 1'b1, 16'h0, 16'h8ABC, 16'h0, 16'hC000);
    chk("b2b_c000", out_phit, 16'hC000);
    chk("b2b_noerr", err_proto, 1'b0);
    cyc(4'b1000, 1'b0, 16'h0, 16'h0, 16'h0, 16'hA5A5);

    // mid-packet reset, then idle
    do_reset();
    cyc(4'b0000, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0);
    chk("post_rst_idle", out_phit, 16'h0);
    // old packet must not continue after reset
    cyc(4'b1000, 1'b0, 16'h0, 16'h0, 16'h0, 16'hA5A5);

    // multi-hot select
    do_reset();
    cyc(4'b0011, 1'b1, 16'hC001, 16'hC002, 16'h0, 16'h0);
    chk("multi_flag", err_multi, 1'b1);
    cyc(4'b0001, 1'b1, 16'hC001, 16'h0, 16'h0, 16'h0);
    chk("multi_sticky", err_multi, 1'b1);

    // payload while idle
    do_reset();
    cyc(4'b0001, 1'b0, 16'h8000, 16'h0, 16'h0, 16'h0);
    chk("idle_pay_proto", err_proto, 1'b1);
    chk("idle_pay_pkt", pkt_count, 16'd0);
    do_reset();
    cyc(4'b0000, 1'b1, 16'hC000, 16'h0, 16'h0, 16'h0);
    chk("shift_nosel", err_proto, 1'b1);

    // randomized traffic
    do_reset();
    for (int k = 0; k < 3000; k++) rnd_cycle();

    // counter wrap with head-only packets
    do_reset();
    for (int k = 0; k < 65536; k++)
      cyc(4'b0001, 1'b1, 16'hC000 | 16'(k % 4096), 16'h0, 16'h0, 16'h0);
    chk("wrap_pkt", pkt_count, 16'd0);
    chk("wrap_phc", phit_count, 16'd0);
    chk("wrap_noerr", {err_multi, err_proto}, 2'b00);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
